// File: rtl/light_phase_engine_pkg.sv
// Shared encodings for the traffic-light phase engine.
//   COL_*      : light colour encoding (one bit per light)
//   state_e    : engine state
//   DEF_TIME   : reset value of every green/red duration
//   NUM_LIGHTS : number of lights driven by the engine
package light_phase_engine_pkg;

  localparam int   NUM_LIGHTS = 4;
  localparam int   DEF_TIME   = 5;

  localparam logic COL_RED    = 1'b0;
  localparam logic COL_GREEN  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

endpackage

// File: rtl/light_phase_slot.sv
// One light's timing state: green/red durations, start colour, current
// colour and countdown.
//   clk, arst_i     : clock, async active-high reset
//   wr_i            : config write targets this light
//   load_start_i    : reload colour/count from (new) start config (IDLE only)
//   tick_i          : phase tick; count down / toggle
//   wr_color_i      : 0 = write green duration, 1 = write red duration
//   wr_start_i      : start colour written with every strobe
//   wr_time_i       : duration value
//   color_o         : current colour (1 = green)
//   remaining_o     : ticks left in the current phase
module light_phase_slot
  import light_phase_engine_pkg::*;
#(
  parameter int TIME_W = 4,
  parameter int DEF_T  = 5
) (
  input  logic              clk,
  input  logic              arst_i,
  input  logic              wr_i,
  input  logic              load_start_i,
  input  logic              tick_i,
  input  logic              wr_color_i,
  input  logic              wr_start_i,
  input  logic [TIME_W-1:0] wr_time_i,
  output logic              color_o,
  output logic [TIME_W-1:0] remaining_o
);

  logic [TIME_W-1:0] green_q, green_d;
  logic [TIME_W-1:0] red_q,   red_d;
  logic              start_q, start_d;
  logic              color_q, color_d;
  logic [TIME_W-1:0] rem_q,   rem_d;

  // A zero duration would stall the countdown; run it as one tick.
  function automatic logic [TIME_W-1:0] min1(input logic [TIME_W-1:0] t);
    return (t == '0) ? TIME_W'(1) : t;
  endfunction

  always_comb begin
    green_d = green_q;
    red_d   = red_q;
    start_d = start_q;
    color_d = color_q;
    rem_d   = rem_q;
    if (wr_i) begin
      if (wr_color_i == 1'b0) green_d = wr_time_i;
      else                    red_d   = wr_time_i;
      start_d = wr_start_i;
    end
    if (tick_i) begin
      // Phase load uses the pre-write durations so a same-edge write
      // only affects the following load.
      if (rem_q <= TIME_W'(1)) begin
        color_d = ~color_q;
        rem_d   = min1((color_q == COL_RED) ? green_q : red_q);
      end else begin
        rem_d   = rem_q - TIME_W'(1);
      end
    end else if (load_start_i) begin
      // IDLE reload shows the freshly written config.
      color_d = start_d;
      rem_d   = min1((start_d == COL_GREEN) ? green_d : red_d);
    end
  end

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      green_q <= TIME_W'(DEF_T);
      red_q   <= TIME_W'(DEF_T);
      start_q <= COL_RED;
      color_q <= COL_RED;
      rem_q   <= TIME_W'(DEF_T);
    end else begin
      green_q <= green_d;
      red_q   <= red_d;
      start_q <= start_d;
      color_q <= color_d;
      rem_q   <= rem_d;
    end
  end

  assign color_o     = color_q;
  assign remaining_o = rem_q;

endmodule

// File: rtl/light_phase_engine.sv
// Timing engine for four traffic lights: holds per-light durations and
// start colours, counts whole-second phases and toggles each light.
//   clk, arst_i   : clock, async active-high reset
//   cfg_we        : one-cycle config write strobe
//   cfg_sel       : target light
//   cfg_color     : 0 = green duration, 1 = red duration
//   cfg_start     : start colour (1 = green)
//   cfg_time      : duration in ticks
//   run           : level, starts the engine from IDLE
//   freeze        : level, halts the engine until reset
//   light_color   : bit i = colour of light i (1 = green)
//   remaining     : light i countdown at [i*TIME_W +: TIME_W]
//   tick_o        : one-cycle pulse per phase tick
//   running_o     : high in RUN only
module light_phase_engine #(
  parameter int TICK_DIV = 100000000,
  parameter int TIME_W   = 4,
  parameter int DEF_TIME = light_phase_engine_pkg::DEF_TIME
) (
  input  logic                clk,
  input  logic                arst_i,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_sel,
  input  logic                cfg_color,
  input  logic                cfg_start,
  input  logic [TIME_W-1:0]   cfg_time,
  input  logic                run,
  input  logic                freeze,
  output logic [3:0]          light_color,
  output logic [4*TIME_W-1:0] remaining,
  output logic                tick_o,
  output logic                running_o
);
  import light_phase_engine_pkg::*;

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_e                                 state_q, state_d;
  logic [DIV_W-1:0]                       div_q, div_d;
  logic                                   tick;
  logic [NUM_LIGHTS-1:0][TIME_W-1:0]      rem_w;
  logic [NUM_LIGHTS-1:0]                  col_w;

  // Derived only from registers, so no input-to-output path.
  assign tick = (state_q == ST_RUN) && (div_q == DIV_W'(TICK_DIV - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (freeze) state_d = ST_HALT;
               else if (run) state_d = ST_RUN;
      ST_RUN:  if (freeze) state_d = ST_HALT;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    div_d = div_q;
    if (state_q == ST_RUN) div_d = tick ? '0 : div_q + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
    end
  end

  for (genvar g = 0; g < NUM_LIGHTS; g++) begin : g_slot
    logic wr;
    assign wr = cfg_we && (cfg_sel == 2'(g));

    light_phase_slot #(
      .TIME_W (TIME_W),
      .DEF_T  (DEF_TIME)
    ) u_slot (
      .clk          (clk),
      .arst_i       (arst_i),
      .wr_i         (wr),
      .load_start_i (wr && (state_q == ST_IDLE)),
      .tick_i       (tick),
      .wr_color_i   (cfg_color),
      .wr_start_i   (cfg_start),
      .wr_time_i    (cfg_time),
      .color_o      (col_w[g]),
      .remaining_o  (rem_w[g])
    );
  end

  assign light_color = col_w;
  assign remaining   = rem_w;
  assign tick_o      = tick;
  assign running_o   = (state_q == ST_RUN);

endmodule

// File: tb/tb_light_phase_engine.sv
// Self-checking bench for light_phase_engine: a behavioural model predicts
// outputs each edge into a scoreboard queue, compared half a cycle later,
// plus directed checks for the notable scenarios.
module tb_light_phase_engine;

  localparam int TD = 4;
  localparam int TW = 4;

  logic            clk = 1'b0;
  logic            arst_i = 1'b0;
  logic            cfg_we = 1'b0;
  logic [1:0]      cfg_sel = '0;
  logic            cfg_color = 1'b0;
  logic            cfg_start = 1'b0;
  logic [TW-1:0]   cfg_time = '0;
  logic            run = 1'b0;
  logic            freeze = 1'b0;
  logic [3:0]      light_color;
  logic [4*TW-1:0] remaining;
  logic            tick_o;
  logic            running_o;

  light_phase_engine #(.TICK_DIV(TD), .TIME_W(TW), .DEF_TIME(5)) dut (
    .clk         (clk),
    .arst_i      (arst_i),
    .cfg_we      (cfg_we),
    .cfg_sel     (cfg_sel),
    .cfg_color   (cfg_color),
    .cfg_start   (cfg_start),
    .cfg_time    (cfg_time),
    .run         (run),
    .freeze      (freeze),
    .light_color (light_color),
    .remaining   (remaining),
    .tick_o      (tick_o),
    .running_o   (running_o)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [3:0]  col;
    logic [15:0] rem;
    logic        tick;
    logic        run;
  } obs_t;

  int         m_st;   // 0 idle, 1 run, 2 halt
  int         m_div;
  logic [3:0] m_col;
  logic [3:0] m_rem [4];
  logic [3:0] m_grn [4];
  logic [3:0] m_red [4];
  logic       m_start [4];
  obs_t       sbq [$];

  function automatic logic [3:0] mn1(input logic [3:0] t);
    return (t == 4'd0) ? 4'd1 : t;
  endfunction

  task automatic model_reset();
    m_st = 0; m_div = 0; m_col = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      m_rem[i] = 4'd5; m_grn[i] = 4'd5; m_red[i] = 4'd5; m_start[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic tk;
    tk = (m_st == 1) && (m_div == TD - 1);
    if (tk) begin
      for (int i = 0; i < 4; i++) begin
        if (m_rem[i] == 4'd1) begin
          m_col[i] = ~m_col[i];
          m_rem[i] = mn1(m_col[i] ? m_grn[i] : m_red[i]);
        end else begin
          m_rem[i] = 4'(m_rem[i] - 4'd1);
        end
      end
    end
    if (cfg_we) begin
      if (cfg_color == 1'b0) m_grn[cfg_sel] = cfg_time;
      else                   m_red[cfg_sel] = cfg_time;
      m_start[cfg_sel] = cfg_start;
      if (m_st == 0) begin
        m_col[cfg_sel] = cfg_start;
        m_rem[cfg_sel] = mn1(cfg_start ? m_grn[cfg_sel] : m_red[cfg_sel]);
      end
    end
    if (m_st == 1) m_div = tk ? 0 : m_div + 1;
    if (m_st != 2 && freeze)   m_st = 2;
    else if (m_st == 0 && run) m_st = 1;
  endtask

  function automatic obs_t m_out();
    obs_t o;
    o.col  = m_col;
    o.rem  = {m_rem[3], m_rem[2], m_rem[1], m_rem[0]};
    o.tick = (m_st == 1) && (m_div == TD - 1);
    o.run  = (m_st == 1);
    return o;
  endfunction

  // One clock: model predicts at the edge, DUT compared on the falling edge.
  task automatic cyc();
    obs_t e;
    @(posedge clk);
    model_step();
    sbq.push_back(m_out());
    @(negedge clk);
    if (sbq.size() == 0) chk("sbq_empty", 32'd0, 32'd1);
    else begin
      e = sbq.pop_front();
      chk("out", 32'({light_color, remaining, tick_o, running_o}), 32'(e));
    end
  endtask

  task automatic do_reset();
    #3 arst_i = 1'b1;
    #1;
    chk("rst_col",  32'(light_color), 32'h0);
    chk("rst_rem",  32'(remaining),   32'h5555);
    chk("rst_tick", 32'(tick_o),      32'h0);
    chk("rst_run",  32'(running_o),   32'h0);
    model_reset();
    sbq.delete();
    @(negedge clk);
    arst_i = 1'b0;
  endtask

  task automatic wr(input logic [1:0] sel, input logic col, input logic st, input logic [3:0] t);
    cfg_we = 1'b1; cfg_sel = sel; cfg_color = col; cfg_start = st; cfg_time = t;
    cyc();
    cfg_we = 1'b0;
  endtask

  initial begin
    int n;
    // 1: default run
    do_reset();
    run = 1'b1;
    repeat (4) cyc();
    chk("t1_tick", 32'(tick_o), 32'd1);
    repeat (16) cyc();
    chk("t1_pre", 32'(light_color), 32'h0);
    cyc();
    chk("t1_col", 32'(light_color), 32'hF);
    chk("t1_rem", 32'(remaining), 32'h5555);

    // 2: IDLE write reloads immediately
    run = 1'b0;
    do_reset();
    wr(2'd2, 1'b0, 1'b1, 4'd3);
    chk("t2_col", 32'(light_color[2]), 32'd1);
    chk("t2_rem", 32'(remaining[11:8]), 32'd3);
    run = 1'b1;
    repeat (12) cyc();
    chk("t2_rem1", 32'(remaining[11:8]), 32'd1);
    cyc();
    chk("t2_tcol", 32'(light_color[2]), 32'd0);
    chk("t2_trem", 32'(remaining[11:8]), 32'd5);

    // 3: RUN write deferred to next load
    n = 0;
    while (!(light_color[0] == 1'b1 && remaining[3:0] == 4'd4) && n < 200) begin cyc(); n++; end
    if (n >= 200) chk("t3_tmo_a", 32'd0, 32'd1);
    wr(2'd0, 1'b1, 1'b0, 4'd2);
    chk("t3_col", 32'(light_color[0]), 32'd1);
    chk("t3_rem", 32'(remaining[3:0]), 32'd4);
    n = 0;
    while (light_color[0] != 1'b0 && n < 200) begin cyc(); n++; end
    if (n >= 200) chk("t3_tmo_b", 32'd0, 32'd1);
    chk("t3_red", 32'(remaining[3:0]), 32'd2);

    // 4: zero durations load as 1, toggle every tick
    run = 1'b0;
    do_reset();
    wr(2'd1, 1'b1, 1'b1, 4'd0);
    wr(2'd1, 1'b0, 1'b1, 4'd0);
    chk("t4_col", 32'(light_color[1]), 32'd1);
    chk("t4_rem", 32'(remaining[7:4]), 32'd1);
    run = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!tick_o && n < 20) begin cyc(); n++; end
      if (n >= 20) chk("t4_tmo", 32'd0, 32'd1);
      cyc();
      chk("t4_tog", 32'(light_color[1]), (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("t4_rem1", 32'(remaining[7:4]), 32'd1);
    end

    // 5: freeze halts everything, run ignored
    freeze = 1'b1;
    cyc();
    chk("t5_run", 32'(running_o), 32'd0);
    for (int i = 0; i < 100; i++) begin
      run = i[0];
      cyc();
      chk("t5_tick", 32'(tick_o), 32'd0);
    end

    // 6: async reset mid-run, restart only on run
    freeze = 1'b0;
    run = 1'b0;
    do_reset();
    run = 1'b1;
    repeat (10) cyc();
    run = 1'b0;
    do_reset();
    repeat (5) cyc();
    chk("t6_idle", 32'(running_o), 32'd0);
    run = 1'b1;
    cyc();
    chk("t6_run", 32'(running_o), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
